button_ctrl: RTL and testbench

BUTTON_CTRL -- requirements
Module: button_ctrl

---
 rtl/button_ctrl_pkg.sv | 16 +
 rtl/debounce.sv | 77 +++++++
 rtl/button_ctrl.sv | 57 +++++
 tb/tb_button_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_ctrl_pkg.sv
// Shared types and constants for the push-button front end.
package button_ctrl_pkg;

   localparam int CNT_W       = 24;
   localparam int PRESS_SS    = 0;
   localparam int PRESS_MODE  = 1;
   localparam int PRESS_SPEED = 2;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer plus stable-level debounce FSM for one button.
// Emits a one-cycle registered strobe when a debounced press is accepted.
module debounce
   import button_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   db_state_t        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             press_q;
   logic             btn_s;

   assign btn_s   = sync_q[1];
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
   assign press_o = press_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= 2'b00;
         state_q <= RELEASED;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         press_q <= 1'b0;
         case (state_q)
            RELEASED: begin
               cnt_q <= '0;
               if (btn_s) state_q <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
                  press_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            PRESSED: begin
               cnt_q <= '0;
               if (!btn_s) state_q <= RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               // a bounce back high returns to PRESSED silently: no second strobe
               if (btn_s) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= RELEASED;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_ctrl.sv
// Debounces start/stop, direction and speed buttons; keeps SS, MODE and sel.
// Outputs update on the edge that ends each one-cycle press strobe.
module button_ctrl
   import button_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk50m,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_mode,
   input  logic       btn_speed,
   output logic       SS,
   output logic       MODE,
   output logic [1:0] sel,
   output logic [2:0] press
);

   logic [2:0] press_w;
   logic       ss_q, ss_d;
   logic       mode_q, mode_d;
   logic [1:0] sel_q, sel_d;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
      .clk_i(clk50m), .rst_i(reset), .btn_i(btn_ss), .press_o(press_w[PRESS_SS])
   );
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk_i(clk50m), .rst_i(reset), .btn_i(btn_mode), .press_o(press_w[PRESS_MODE])
   );
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
      .clk_i(clk50m), .rst_i(reset), .btn_i(btn_speed), .press_o(press_w[PRESS_SPEED])
   );

   always_comb begin
      ss_d   = ss_q ^ press_w[PRESS_SS];
      mode_d = mode_q ^ press_w[PRESS_MODE];
      sel_d  = press_w[PRESS_SPEED] ? sel_q + 2'd1 : sel_q;
   end

   always_ff @(posedge clk50m or posedge reset) begin
      if (reset) begin
         ss_q   <= 1'b0;
         mode_q <= 1'b0;
         sel_q  <= 2'b00;
      end else begin
         ss_q   <= ss_d;
         mode_q <= mode_d;
         sel_q  <= sel_d;
      end
   end

   assign SS    = ss_q;
   assign MODE  = mode_q;
   assign sel   = sel_q;
   assign press = press_w;

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl with a short debounce window: directed tables and
// sequences plus random button activity against a level/run-length model.
module tb_button_ctrl;

   localparam int D = 4;

   logic       clk50m;
   logic       reset;
   logic       btn_ss, btn_mode, btn_speed;
   logic       SS, MODE;
   logic [1:0] sel;
   logic [2:0] press;

   button_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
      .clk50m(clk50m), .reset(reset),
      .btn_ss(btn_ss), .btn_mode(btn_mode), .btn_speed(btn_speed),
      .SS(SS), .MODE(MODE), .sel(sel), .press(press)
   );

   initial clk50m = 1'b0;
   always #5 clk50m = ~clk50m;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: each button has an accepted level; it flips once the synchronized
   // input has disagreed with it for D+1 consecutive samples.
   bit         h1[3], h2[3], lvl[3];
   int         run[3];
   bit [2:0]   mpress;
   bit         mss, mmode;
   bit [1:0]   msel;

   typedef struct {
      bit       ss, md, sp;
      bit       exp_ss, exp_mode;
      bit [1:0] exp_sel;
      bit [2:0] exp_press;
   } vec_t;
   vec_t vecs[12];

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         h1[i] = 0; h2[i] = 0; lvl[i] = 0; run[i] = 0;
      end
      mpress = 3'b000; mss = 0; mmode = 0; msel = 2'b00;
   endtask

   task automatic model_step(input bit [2:0] raw);
      if (mpress[0]) mss = ~mss;
      if (mpress[1]) mmode = ~mmode;
      if (mpress[2]) msel = msel + 2'd1;
      mpress = 3'b000;
      for (int i = 0; i < 3; i++) begin
         bit s;
         s = h2[i];
         h2[i] = h1[i];
         h1[i] = raw[i];
         if (s != lvl[i]) begin
            run[i]++;
            if (run[i] == D + 1) begin
               lvl[i] = s;
               run[i] = 0;
               mpress[i] = s;
            end
         end else begin
            run[i] = 0;
         end
      end
   endtask

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      n_cmp++;
      if ({SS, MODE, sel, press} !== {mss, mmode, msel, mpress}) begin
         n_bad++;
         $display("FAIL %s @%0t: got SS=%b MODE=%b sel=%b press=%b expected SS=%b MODE=%b sel=%b press=%b",
                  tag, $time, SS, MODE, sel, press, mss, mmode, msel, mpress);
      end
   endtask

   // Called at a falling edge: drive inputs, clock once, sample at next falling edge.
   task automatic cycle(input bit ss, input bit md, input bit sp, input bit rst, input string tag);
      btn_ss = ss; btn_mode = md; btn_speed = sp; reset = rst;
      if (rst) model_reset();
      @(posedge clk50m);
      if (!rst) model_step({sp, md, ss});
      @(negedge clk50m);
      chk_model(tag);
   endtask

   task automatic do_reset();
      cycle(0, 0, 0, 1, "reset_hold");
      cycle(0, 0, 0, 1, "reset_hold");
      reset = 1'b0;
      chk_val("reset_state", {28'd0, SS, MODE, sel, press}, 32'd0);
   endtask

   initial begin
      int pc[3];
      int row0, row1;
      int hold[3];
      bit [2:0] lv;
      bit [1:0] sel_exp[5];

      sel_exp[0] = 2'b01; sel_exp[1] = 2'b10; sel_exp[2] = 2'b11;
      sel_exp[3] = 2'b00; sel_exp[4] = 2'b01;
      for (int i = 0; i < 12; i++)
         vecs[i] = '{1'b1, 1'b0, 1'b0, (i >= 7), 1'b0, 2'b00, (i == 6) ? 3'b001 : 3'b000};

      reset = 1'b1; btn_ss = 0; btn_mode = 0; btn_speed = 0;
      model_reset();
      #1;
      chk_val("reset_async", {28'd0, SS, MODE, sel, press}, 32'd0);
      @(negedge clk50m);
      do_reset();

      // Held start/stop: one strobe at row 6, SS set from row 7
      pc[0] = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(vecs[i].ss, vecs[i].md, vecs[i].sp, 0, "ss_hold_model");
         chk_val($sformatf("ss_hold_row%0d", i),
                 {27'd0, SS, MODE, sel, press},
                 {27'd0, vecs[i].exp_ss, vecs[i].exp_mode, vecs[i].exp_sel, vecs[i].exp_press});
         pc[0] += press[0];
      end
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 0, 0, "ss_hold_model");
         pc[0] += press[0];
      end
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 0, 0, "ss_release_model");
         pc[0] += press[0];
      end
      chk_val("ss_hold_one_pulse", pc[0], 1);
      chk_val("ss_hold_final", {29'd0, SS, MODE, sel}, {29'd0, 1'b1, 1'b0, 2'b00});

      // Chattering mode button: never stable long enough
      do_reset();
      pc[1] = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, (i % 2) == 0, 0, 0, "mode_bounce_model");
         pc[1] += press[1];
      end
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 0, 0, "mode_bounce_model");
         pc[1] += press[1];
      end
      chk_val("mode_bounce_no_pulse", pc[1], 0);
      chk_val("mode_bounce_mode", MODE, 0);

      // Five clean speed presses walk sel around modulo 4
      do_reset();
      for (int p = 0; p < 5; p++) begin
         for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, "speed_model");
         chk_val($sformatf("speed_sel_%0d", p), sel, sel_exp[p]);
         for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, "speed_model");
      end

      // Simultaneous ss and mode presses land in the same cycle
      do_reset();
      row0 = -1; row1 = -1;
      for (int i = 0; i < 10; i++) begin
         cycle(1, 1, 0, 0, "dual_model");
         if (press[0] && row0 < 0) row0 = i;
         if (press[1] && row1 < 0) row1 = i;
         if (i == 6) chk_val("dual_press_row6", press, 3'b011);
      end
      chk_val("dual_same_cycle", row0, row1);
      chk_val("dual_outputs", {30'd0, SS, MODE}, 32'd3);

      // Reset mid-debounce with button held: pending press discarded, re-debounced
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, "rst_mid_model");
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, "rst_mid_model");
      chk_val("rst_mid_ss_before", SS, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "rst_mid_model");
      reset = 1'b1;
      #1;
      chk_val("rst_mid_ss_immediate", SS, 0);
      @(negedge clk50m);
      cycle(1, 0, 0, 1, "rst_mid_model");
      pc[0] = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1, 0, 0, 0, "rst_mid_model");
         pc[0] += press[0];
         if (i == 6) chk_val("rst_mid_press_row6", press, 3'b001);
         if (i == 7) chk_val("rst_mid_ss_row7", SS, 1);
      end
      chk_val("rst_mid_one_pulse", pc[0], 1);

      // Short low glitch while pressed: stays pressed, no new strobe
      do_reset();
      for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, "glitch_model");
      pc[0] = 0;
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 0, 0, "glitch_model");
         pc[0] += press[0];
      end
      for (int i = 0; i < 14; i++) begin
         cycle(1, 0, 0, 0, "glitch_model");
         pc[0] += press[0];
      end
      chk_val("glitch_no_pulse", pc[0], 0);
      chk_val("glitch_ss", SS, 1);

      // Random bursts of varying length on all three buttons, with rare resets
      do_reset();
      lv = 3'b000;
      for (int i = 0; i < 3; i++) hold[i] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (hold[i] == 0) begin
               lv[i] = $urandom_range(0, 1);
               hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(D + 3, 20)
                                                     : $urandom_range(1, D + 2);
            end
            hold[i]--;
         end
         cycle(lv[0], lv[1], lv[2], ($urandom_range(0, 299) == 0), "random_model");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
